// File: rtl/ls_pkg.sv
// Shared encodings for the load/store unit: micro-op codes, FSM states and
// small decode helpers used by the unit and its queue.
package ls_pkg;

  localparam int UFOP_W = 3;

  typedef enum logic [UFOP_W-1:0] {
    UFOP_NOP   = 3'd0,
    UFOP_LOAD  = 3'd4,
    UFOP_STORE = 3'd5
  } ufop_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_READ  = 2'd2,
    ST_BCAST = 2'd3
  } ls_state_t;

  // Any encoding other than LOAD/STORE behaves as a NOP.
  function automatic logic is_load(input logic [UFOP_W-1:0] op);
    return (op == UFOP_LOAD);
  endfunction

  function automatic logic is_store(input logic [UFOP_W-1:0] op);
    return (op == UFOP_STORE);
  endfunction

endpackage

// File: rtl/fila_ls.sv
// In-order operation queue for the load/store unit: circular buffer with
// wrapping pointers, occupancy count and a synchronous flush.
module fila_ls #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  // A full queue ignores pushes even if a pop happens on the same edge.
  assign push_s = push && !full && !Clear;
  assign pop_s  = pop && !empty && !Clear;
  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == {CNT_W{1'b0}});
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge Clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (Clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit: queues issued memory operations and executes them in order,
// driving an external synchronous memory and broadcasting load results on the CDB.
module unidade_load_store
  import ls_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 3
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Clear,
  input  logic                   Issue_valid,
  output logic                   Issue_ready,
  input  logic [UFOP_W-1:0]      Ufop,
  input  logic [DATA_W-1:0]      A,
  input  logic [DATA_W-1:0]      Imm,
  input  logic [DATA_W-1:0]      Sd,
  input  logic [TAG_W-1:0]       Tag,
  output logic [ADDR_W-1:0]      Mem_addr,
  output logic                   Mem_wren,
  output logic [DATA_W-1:0]      Mem_din,
  input  logic [DATA_W-1:0]      Mem_q,
  output logic                   Cdb_req,
  input  logic                   Cdb_grant,
  output logic                   Write_Enable_CDB,
  output logic [DATA_W-1:0]      Q,
  output logic [TAG_W-1:0]       Cdb_tag,
  output logic                   Done,
  output logic                   Busy,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int ENTRY_W = UFOP_W + ADDR_W + DATA_W + TAG_W;

  logic [ENTRY_W-1:0] entry_in_s;
  logic [ENTRY_W-1:0] head_s;
  logic [UFOP_W-1:0]  head_op_s;
  logic [ADDR_W-1:0]  head_addr_s;
  logic [DATA_W-1:0]  head_sd_s;
  logic [TAG_W-1:0]   head_tag_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;

  ls_state_t          state_r;
  logic [UFOP_W-1:0]  op_r;
  logic [TAG_W-1:0]   tag_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic               mem_wren_r;
  logic [DATA_W-1:0]  mem_din_r;
  logic [DATA_W-1:0]  q_r;
  logic [TAG_W-1:0]   cdb_tag_r;
  logic               cdb_req_r;
  logic               done_r;

  // Effective address keeps only the low ADDR_W bits; the carry is dropped.
  assign entry_in_s = {Ufop, ADDR_W'(A + Imm), Sd, Tag};
  assign {head_op_s, head_addr_s, head_sd_s, head_tag_s} = head_s;

  assign push_s = Issue_valid && !full_s;
  assign pop_s  = (state_r == ST_IDLE) && !empty_s;

  fila_ls #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fila (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Clear   (Clear),
    .push    (push_s),
    .pop     (pop_s),
    .din     (entry_in_s),
    .dout    (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (Count)
  );

  assign Issue_ready      = !full_s;
  assign Busy             = !empty_s || (state_r != ST_IDLE);
  assign Write_Enable_CDB = cdb_req_r && Cdb_grant;
  assign Mem_addr         = mem_addr_r;
  assign Mem_wren         = mem_wren_r;
  assign Mem_din          = mem_din_r;
  assign Q                = q_r;
  assign Cdb_tag          = cdb_tag_r;
  assign Cdb_req          = cdb_req_r;
  assign Done             = done_r;

  // Execution FSM; memory strobes are set on the pop edge so they are valid throughout EXEC.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r    <= ST_IDLE;
      op_r       <= {UFOP_W{1'b0}};
      tag_r      <= {TAG_W{1'b0}};
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_wren_r <= 1'b0;
      mem_din_r  <= {DATA_W{1'b0}};
      q_r        <= {DATA_W{1'b0}};
      cdb_tag_r  <= {TAG_W{1'b0}};
      cdb_req_r  <= 1'b0;
      done_r     <= 1'b0;
    end else if (Clear) begin
      state_r    <= ST_IDLE;
      mem_wren_r <= 1'b0;
      mem_din_r  <= {DATA_W{1'b0}};
      cdb_req_r  <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      mem_wren_r <= 1'b0;
      mem_din_r  <= {DATA_W{1'b0}};
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            op_r       <= head_op_s;
            tag_r      <= head_tag_s;
            mem_addr_r <= head_addr_s;
            if (is_store(head_op_s)) begin
              mem_wren_r <= 1'b1;
              mem_din_r  <= head_sd_s;
            end
            state_r <= ST_EXEC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (is_load(op_r)) begin
            state_r <= ST_READ;
          end else begin
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          q_r       <= Mem_q;
          cdb_tag_r <= tag_r;
          cdb_req_r <= 1'b1;
          state_r   <= ST_BCAST;
        end
        ST_BCAST: begin
          if (Cdb_grant) begin
            cdb_req_r <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_BCAST;
          end
        end
        default: begin
          cdb_req_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_load_store.sv
// Self-checking bench for unidade_load_store: a transaction-level model of the
// queue and the unit's per-operation timeline, directed scenarios, then random traffic.
module tb_unidade_load_store;

  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Clear = 1'b0;
  logic        Issue_valid = 1'b0;
  logic        Issue_ready;
  logic [2:0]  Ufop = 3'd0;
  logic [15:0] A = 16'd0;
  logic [15:0] Imm = 16'd0;
  logic [15:0] Sd = 16'd0;
  logic [2:0]  Tag = 3'd0;
  logic [3:0]  Mem_addr;
  logic        Mem_wren;
  logic [15:0] Mem_din;
  logic [15:0] Mem_q;
  logic        Cdb_req;
  logic        Cdb_grant = 1'b0;
  logic        Write_Enable_CDB;
  logic [15:0] Q;
  logic [2:0]  Cdb_tag;
  logic        Done;
  logic        Busy;
  logic [2:0]  Count;

  unidade_load_store dut (
    .Clock(Clock), .Reset_n(Reset_n), .Clear(Clear),
    .Issue_valid(Issue_valid), .Issue_ready(Issue_ready),
    .Ufop(Ufop), .A(A), .Imm(Imm), .Sd(Sd), .Tag(Tag),
    .Mem_addr(Mem_addr), .Mem_wren(Mem_wren), .Mem_din(Mem_din), .Mem_q(Mem_q),
    .Cdb_req(Cdb_req), .Cdb_grant(Cdb_grant), .Write_Enable_CDB(Write_Enable_CDB),
    .Q(Q), .Cdb_tag(Cdb_tag), .Done(Done), .Busy(Busy), .Count(Count)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] init_val(input int i);
    return (16'(i) * 16'h1357) ^ 16'h5A5A;
  endfunction

  // External synchronous memory: one-cycle read latency, write on Mem_wren.
  logic [15:0] tmem [16];
  logic [15:0] mem_q_r;
  assign Mem_q = mem_q_r;
  always @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) tmem[i] <= init_val(i);
      mem_q_r <= 16'd0;
    end else begin
      if (Mem_wren) tmem[Mem_addr] <= Mem_din;
      mem_q_r <= tmem[Mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]  uf;
    logic [3:0]  addr;
    logic [15:0] sd;
    logic [2:0]  tag;
  } op_t;

  op_t         mq[$];
  op_t         cur;
  bit          cur_v = 1'b0;
  int          k = 0;        // cycles since the current op left the queue (1 = memory access cycle)
  bit          exp_done = 1'b0;
  bit          accepted = 1'b0;
  logic [15:0] exp_q = 16'd0;
  logic [15:0] mmem [16];

  task automatic model_reset();
    mq.delete();
    cur_v = 1'b0;
    k = 0;
    exp_done = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 16; i++) mmem[i] = init_val(i);
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit idle_pre;
    bit had_room;
    op_t n;
    idle_pre = !cur_v;
    had_room = (mq.size() < DEPTH);
    exp_done = 1'b0;
    if (cur_v && k == 1 && cur.uf == 3'd5) mmem[cur.addr] = cur.sd;
    if (Clear) begin
      mq.delete();
      cur_v = 1'b0;
      accepted = 1'b0;
    end else begin
      if (cur_v) begin
        if (cur.uf == 3'd4) begin
          if (k >= 3) begin
            if (Cdb_grant) begin
              cur_v = 1'b0;
              exp_done = 1'b1;
            end
          end else begin
            if (k == 1) exp_q = mmem[cur.addr];
            k++;
          end
        end else begin
          cur_v = 1'b0;
          exp_done = 1'b1;
        end
      end
      if (idle_pre && mq.size() > 0) begin
        cur = mq.pop_front();
        cur_v = 1'b1;
        k = 1;
      end
      accepted = Issue_valid && had_room;
      if (accepted) begin
        n.uf   = Ufop;
        n.addr = 4'((int'(A) + int'(Imm)) % 16);
        n.sd   = Sd;
        n.tag  = Tag;
        mq.push_back(n);
      end
    end
  endtask

  // Compare every observable output with the model for the current cycle.
  task automatic compare();
    bit e_wren;
    bit e_req;
    e_wren = cur_v && k == 1 && cur.uf == 3'd5;
    e_req  = cur_v && k == 3 && cur.uf == 3'd4;
    chk("issue_ready", 32'(Issue_ready), 32'(mq.size() < DEPTH));
    chk("count", 32'(Count), 32'(mq.size()));
    chk("busy", 32'(Busy), 32'(mq.size() > 0 || cur_v));
    chk("done", 32'(Done), 32'(exp_done));
    chk("mem_wren", 32'(Mem_wren), 32'(e_wren));
    chk("cdb_req", 32'(Cdb_req), 32'(e_req));
    chk("we_cdb", 32'(Write_Enable_CDB), 32'(e_req && Cdb_grant));
    if (cur_v && k == 1) chk("mem_addr", 32'(Mem_addr), 32'(cur.addr));
    if (e_wren) chk("mem_din", 32'(Mem_din), 32'(cur.sd));
    if (e_req) begin
      chk("q", 32'(Q), 32'(exp_q));
      chk("cdb_tag", 32'(Cdb_tag), 32'(cur.tag));
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then let the rising edge happen.
  task automatic cycle(input bit clr, input bit iv, input logic [2:0] uf,
                       input logic [15:0] a, input logic [15:0] imm, input logic [15:0] sd,
                       input logic [2:0] tg, input bit gnt);
    Clear = clr; Issue_valid = iv; Ufop = uf; A = a; Imm = imm; Sd = sd; Tag = tg;
    Cdb_grant = gnt;
    #1;
    compare();
    model_edge();
    @(negedge Clock);
  endtask

  task automatic idle(input bit gnt);
    cycle(1'b0, 1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 3'd0, gnt);
  endtask

  task automatic reset_now();
    Clear = 1'b0; Issue_valid = 1'b0; Cdb_grant = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_cdb_tag", 32'(Cdb_tag), 32'd0);
    chk("rst_cdb_req", 32'(Cdb_req), 32'd0);
    chk("rst_we_cdb", 32'(Write_Enable_CDB), 32'd0);
    chk("rst_mem_wren", 32'(Mem_wren), 32'd0);
    chk("rst_mem_din", 32'(Mem_din), 32'd0);
    chk("rst_mem_addr", 32'(Mem_addr), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_issue_ready", 32'(Issue_ready), 32'd1);
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit got;
    logic [2:0] uf;
    #2;
    reset_now();

    // Store then load of the same word, immediate grant.
    cycle(1'b0, 1'b1, 3'd5, 16'd3, 16'd2, 16'hBEEF, 3'd0, 1'b1);
    idle(1'b1);
    chk("st_wren_2nd_cycle", 32'(Mem_wren), 32'd1);
    chk("st_addr_5", 32'(Mem_addr), 32'd5);
    chk("st_din_beef", 32'(Mem_din), 32'hBEEF);
    repeat (3) idle(1'b1);
    cycle(1'b0, 1'b1, 3'd4, 16'd5, 16'd0, 16'd0, 3'd2, 1'b1);
    repeat (3) idle(1'b1);
    chk("ld_we_4th_cycle", 32'(Write_Enable_CDB), 32'd1);
    chk("ld_q_beef", 32'(Q), 32'hBEEF);
    chk("ld_tag_2", 32'(Cdb_tag), 32'd2);
    repeat (3) idle(1'b1);

    // Fill the queue behind a stalled load.
    cycle(1'b0, 1'b1, 3'd4, 16'd9, 16'd0, 16'd0, 3'd7, 1'b0);
    repeat (3) idle(1'b0);
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 1'b1, 3'd4, 16'(j), 16'd1, 16'd0, 3'(j), 1'b0);
      chk("fill_count", 32'(Count), 32'(j + 1));
    end
    chk("full_ready_low", 32'(Issue_ready), 32'd0);
    repeat (3) begin
      cycle(1'b0, 1'b1, 3'd5, 16'd8, 16'd0, 16'h0F0F, 3'd4, 1'b0);
      chk("full_offer_ignored", 32'(Count), 32'd4);
    end
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++) begin
      cycle(1'b0, 1'b1, 3'd5, 16'd8, 16'd0, 16'h0F0F, 3'd4, 1'b1);
      got = accepted;
    end
    chk("fifth_accepted", 32'(got), 32'd1);
    repeat (40) idle(1'b1);
    chk("drained_busy", 32'(Busy), 32'd0);

    // Load with the grant withheld for three BCAST cycles.
    cycle(1'b0, 1'b1, 3'd4, 16'd1, 16'd1, 16'd0, 3'd5, 1'b0);
    repeat (3) idle(1'b0);
    repeat (3) begin
      chk("hold_req", 32'(Cdb_req), 32'd1);
      chk("hold_q", 32'(Q), 32'(init_val(2)));
      chk("hold_done_low", 32'(Done), 32'd0);
      idle(1'b0);
    end
    idle(1'b1);
    chk("grant_done_pulse", 32'(Done), 32'd1);
    idle(1'b0);
    chk("done_single", 32'(Done), 32'd0);

    // Address wrap with carry dropped.
    cycle(1'b0, 1'b1, 3'd5, 16'hFFFF, 16'h0002, 16'h1234, 3'd0, 1'b1);
    idle(1'b1);
    chk("wrap_addr_1", 32'(Mem_addr), 32'd1);
    chk("wrap_wren", 32'(Mem_wren), 32'd1);
    repeat (3) idle(1'b1);

    // Clear during BCAST with two queued, racing a new issue.
    cycle(1'b0, 1'b1, 3'd4, 16'd7, 16'd0, 16'd0, 3'd1, 1'b0);
    repeat (3) idle(1'b0);
    cycle(1'b0, 1'b1, 3'd5, 16'd6, 16'd0, 16'h7777, 3'd0, 1'b0);
    cycle(1'b0, 1'b1, 3'd4, 16'd6, 16'd0, 16'd0, 3'd3, 1'b0);
    chk("pre_clear_count", 32'(Count), 32'd2);
    cycle(1'b1, 1'b1, 3'd4, 16'd2, 16'd0, 16'd0, 3'd6, 1'b0);
    chk("clr_req", 32'(Cdb_req), 32'd0);
    chk("clr_count", 32'(Count), 32'd0);
    chk("clr_busy", 32'(Busy), 32'd0);
    repeat (2) idle(1'b1);

    // Reset asserted in the middle of a store's EXEC cycle.
    cycle(1'b0, 1'b1, 3'd5, 16'd4, 16'd0, 16'h5555, 3'd0, 1'b1);
    idle(1'b1);
    chk("exec_before_reset", 32'(Mem_wren), 32'd1);
    #2;
    reset_now();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 5))
        0:       uf = 3'd0;
        1, 2:    uf = 3'd4;
        3, 4:    uf = 3'd5;
        default: uf = 3'($urandom_range(0, 7));
      endcase
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60, uf,
            16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
            $urandom_range(0, 99) < 50);
    end
    repeat (30) idle(1'b1);
    chk("final_idle", 32'(Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unidade_load_store.md
UNIDADE_LOAD_STORE -- requirements
Module: unidade_load_store

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 16, data/operand width
- ADDR_W, 4, memory address width
- DEPTH, 4, queue entries (power of two, >=2)
- TAG_W, 3, reservation-station tag width
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clock, in, 1, single clock, rising edge
- Reset_n, in, 1, asynchronous active-low reset
- Clear, in, 1, synchronous flush
- Issue_valid, in, 1, reservation station offers an operation
- Issue_ready, out, 1, queue can accept
- Ufop, in, 3, 0=NOP, 4=Load, 5=Store; others = NOP
- A, in, DATA_W, base operand
- Imm, in, DATA_W, offset
- Sd, in, DATA_W, store data
- Tag, in, TAG_W, destination tag
- Mem_addr, out, ADDR_W, memory address
- Mem_wren, out, 1, memory write enable
- Mem_din, out, DATA_W, memory write data
- Mem_q, in, DATA_W, memory read data (synchronous read, 1-cycle latency)
- Cdb_req, out, 1, request for the CDB
- Cdb_grant, in, 1, CDB arbiter grant
- Write_Enable_CDB, out, 1, result driven on CDB this cycle
- Q, out, DATA_W, load result
- Cdb_tag, out, TAG_W, tag of Q
- Done, out, 1, one-cycle completion pulse
- Busy, out, 1, queue non-empty or FSM not IDLE
- Count, out, clog2(DEPTH)+1, queue occupancy

Function
REQ-003 An issue SHALL be accepted on an edge with Issue_valid=1 and Issue_ready=1; the entry stores Ufop, addr=(A+Imm)[ADDR_W-1:0] with carry discarded, Sd, and Tag.
REQ-004 Issue_ready SHALL equal (Count<DEPTH) and SHALL NOT use same-cycle pop bypass; an offer while full SHALL be ignored.
REQ-005 Execution SHALL be in order, one operation at a time, with read/write pointers wrapping modulo DEPTH.
REQ-006 FSM states IDLE, EXEC, READ, BCAST; IDLE->EXEC pops the head when the queue is non-empty.
REQ-007 EXEC SHALL drive Mem_addr=addr; for Store, Mem_wren=1 and Mem_din=Sd for exactly that cycle; Store/NOP -> IDLE, Load -> READ.
REQ-008 READ SHALL register Mem_q into Q and Tag into Cdb_tag, then go to BCAST.
REQ-009 In BCAST, Cdb_req SHALL be 1; Write_Enable_CDB SHALL equal Cdb_req AND Cdb_grant; on grant, the FSM goes to IDLE, otherwise it holds with Q and Cdb_tag stable.
REQ-010 Done SHALL pulse one cycle after the Store/NOP EXEC cycle or the granted BCAST cycle.
REQ-011 Latency with an empty queue, idle FSM, and immediate grant:
- Load: Write_Enable_CDB in the 4th cycle after the issue edge
- Store: Mem_wren in the 2nd cycle after the issue edge
REQ-012 Clear SHALL empty the queue, return the FSM to IDLE, deassert Cdb_req, Mem_wren, and Done, and SHALL take priority over a same-cycle issue; a store already written SHALL remain in memory.
REQ-013 Issue and pop on the same edge SHALL leave Count unchanged.

Reset
REQ-014 While Reset_n=0, the following SHALL be 0 asynchronously, regardless of Clock, and SHALL remain so until the first edge after release: Q, Cdb_tag, Cdb_req, Write_Enable_CDB, Mem_wren, Mem_din, Mem_addr, Done, Busy, Count, and the pointers; the FSM SHALL be in IDLE; Issue_ready SHALL be 1.

Structure
REQ-015 Ufop encodings (NOP/LOAD/STORE) and FSM state encodings SHALL reside in the shared package ls_pkg.
REQ-016 The queue SHALL be a sub-module fila_ls (parameters DEPTH and width) with push/pop/full/empty/count; the memory SHALL stay outside this block.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Store A=3, Imm=2, Sd=0xBEEF, then Load A=5, Imm=0, Tag=2, grant held 1: Mem_wren at addr 5, then Q=0xBEEF with Cdb_tag=2 and Write_Enable_CDB 4 cycles after the load issue edge.
- Issue 5 ops with DEPTH=4 and grant 0: Issue_ready drops at Count=4; the 5th offer is not accepted until the queue frees a slot.
- Load with grant withheld 3 cycles: Cdb_req held, Q stable, Done pulses once, one cycle after the grant cycle.
- A=0xFFFF, Imm=0x0002 Store: Mem_addr=1 (wrap, carry dropped).
- Clear during BCAST with 2 queued: Cdb_req=0, Count=0, Busy=0 next cycle; Reset_n low mid-EXEC: all outputs 0 immediately.
